// File: rtl/wc_pkg.sv
// Shared constants and FSM state type for the Winograd F(5,3) tile scheduler.
package wc_pkg;

    localparam int NIN     = 7;
    localparam int NOUT    = 5;
    localparam int STRIDE  = 5;
    localparam int OVERLAP = 2;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        NEXT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/wc_out_fifo.sv
// Result FIFO with first-word-fall-through read and an occupancy count.
module wc_out_fifo #(
    parameter int DW    = 51,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Empty FIFO presents zero so the output bus is quiet when nothing is valid.
    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/wc_tile_sched.sv
// Cuts a sample stream into overlapping 7-sample tiles, issues them to WC
// against output credit, and buffers the 5-sample results.
//   state | meaning
//   FIRST | start of row, collecting 7 fresh samples
//   NEXT  | 2 retained samples in slots 0,1, collecting 5 fresh samples
//   HOLD  | complete tile staged, waiting for credit; s_ready low
module wc_tile_sched
    import wc_pkg::*;
#(
    parameter int W         = 10,
    parameter int LAT       = 6,
    parameter int OUT_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [W-1:0]        s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [NOUT*W-1:0]   m_data,
    output logic                m_last,
    output logic [NIN*W-1:0]    wc_d,
    input  logic [NOUT*W-1:0]   wc_z,
    output logic                busy
);

    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(OUT_DEPTH);

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    stage [NIN];
    logic [W-1:0]    tile  [NIN];
    logic [2:0]      cnt;
    logic            hold_last;
    logic            rdy_en;
    logic [LAT-1:0]  pv;
    logic [LAT-1:0]  pl;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            accept;
    logic            complete;
    logic            credit_ok;
    logic            issue;
    logic            issue_last;
    logic            pop;
    logic            push;

    assign s_ready     = rdy_en && (state != HOLD);
    assign accept      = s_valid && s_ready;
    assign pop         = m_valid && m_ready;
    assign push        = pv[LAT-1];
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    assign credit_ok   = credit_used < CREDIT_MAX;
    assign complete    = (state == HOLD) || (accept && ((cnt == 3'd6) || s_last));
    assign issue_last  = (state == HOLD) ? hold_last : s_last;
    assign issue       = complete && credit_ok;

    // Candidate tile: staged samples, the incoming sample, zero padding above it.
    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            tile[i] = '0;
            if (state == HOLD || i < int'(cnt)) begin
                tile[i] = stage[i];
            end else if (i == int'(cnt)) begin
                tile[i] = s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (issue) begin
            state_nxt = issue_last ? FIRST : NEXT;
        end else if (complete) begin
            state_nxt = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en    <= 1'b0;
            cnt       <= '0;
            hold_last <= 1'b0;
            wc_d      <= '0;
            pv        <= '0;
            pl        <= '0;
            inflight  <= '0;
            for (int i = 0; i < NIN; i++) begin
                stage[i] <= '0;
            end
        end else begin
            rdy_en   <= 1'b1;
            pv       <= {pv[LAT-2:0], issue};
            pl       <= {pl[LAT-2:0], issue && issue_last};
            inflight <= inflight + CW'(issue) - CW'(push);
            if (issue) begin
                for (int i = 0; i < NIN; i++) begin
                    wc_d[(NIN-1-i)*W +: W] <= tile[i];
                end
                if (issue_last) begin
                    cnt <= '0;
                end else begin
                    stage[0] <= tile[STRIDE];
                    stage[1] <= tile[STRIDE+1];
                    cnt      <= 3'(OVERLAP);
                end
            end else if (accept && complete) begin
                for (int i = 0; i < NIN; i++) begin
                    stage[i] <= tile[i];
                end
                hold_last <= s_last;
            end else if (accept) begin
                stage[cnt] <= s_data;
                cnt        <= cnt + 3'd1;
            end
        end
    end

    wc_out_fifo #(
        .DW    (NOUT*W + 1),
        .DEPTH (OUT_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({pl[LAT-1], wc_z}),
        .pop       (pop),
        .pop_data  ({m_last, m_data}),
        .count     (fifo_count)
    );

    assign m_valid = (fifo_count != '0);
    assign busy    = (cnt != '0) || (state == HOLD) || (|pv) || (fifo_count != '0);

endmodule

// File: tb/tb_wc_tile_sched.sv
// Randomized scoreboard bench for wc_tile_sched with a behavioural WC stand-in.
module tb_wc_tile_sched;

    localparam int W         = 10;
    localparam int LAT       = 6;
    localparam int OUT_DEPTH = 8;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [5*W-1:0]   m_data;
    logic             m_last;
    logic [7*W-1:0]   wc_d;
    logic [5*W-1:0]   wc_z;
    logic             busy;

    int checks      = 0;
    int failures    = 0;
    int acc_cnt     = 0;
    int mready_mode = 1;

    logic [5*W:0]   exp_q [$];
    logic [7*W-1:0] model_last_tile;
    logic [7*W-1:0] dh [LAT-1];

    wc_tile_sched #(.W(W), .LAT(LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .wc_d    (wc_d),
        .wc_z    (wc_z),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // WC stand-in: 3-tap correlation with taps (1,-2,3), truncated to W bits.
    function automatic logic [5*W-1:0] wc_f(input logic [7*W-1:0] d);
        logic [5*W-1:0] z;
        int a [7];
        int s;
        z = '0;
        for (int i = 0; i < 7; i++) a[i] = int'($signed(d[(6-i)*W +: W]));
        for (int i = 0; i < 5; i++) begin
            s = a[i] - 2 * a[i+1] + 3 * a[i+2];
            z[(4-i)*W +: W] = s[W-1:0];
        end
        return z;
    endfunction

    // wc_d set at edge k appears on wc_z before edge k+LAT.
    always @(posedge clk) begin
        dh[0] <= wc_d;
        for (int j = 1; j < LAT-1; j++) dh[j] <= dh[j-1];
    end
    assign wc_z = wc_f(dh[LAT-2]);

    // Row model: tile t covers samples 5t..5t+6 zero-padded; last tile reaches the row end.
    function automatic void model_row(input logic [W-1:0] row [$]);
        int len;
        int t;
        bit lst;
        logic [7*W-1:0] d;
        len = row.size();
        t   = 0;
        lst = 1'b0;
        while (!lst) begin
            d = '0;
            for (int i = 0; i < 7; i++) begin
                if (5*t + i < len) d[(6-i)*W +: W] = row[5*t + i];
            end
            lst = (len <= 5*t + 7);
            exp_q.push_back({lst, wc_f(d)});
            model_last_tile = d;
            t++;
        end
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && s_valid && s_ready) acc_cnt++;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [5*W:0] e;
        if (rst_n && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result actual=%0h required=none", {m_last, m_data});
            end else begin
                e = exp_q.pop_front();
                if ({m_last, m_data} !== e) begin
                    failures++;
                    $display("FAIL result actual=%0h required=%0h", {m_last, m_data}, e);
                end
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic l, input int limit);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready_low_%0d_cycles required=ready", n);
        end else begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_row(input logic [W-1:0] row [$], input bit gaps, input int limit);
        model_row(row);
        @(posedge clk);
        #1;
        foreach (row[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(row[i], (i == row.size() - 1), limit);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_queue"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    function automatic void seq_row(output logic [W-1:0] row [$], input int first, input int len);
        row = {};
        for (int i = 0; i < len; i++) row.push_back(W'(first + i));
    endfunction

    initial begin
        logic [W-1:0] row [$];
        int spec_row [7] = '{2, -10, 3, 4, -13, -18, -16};
        logic [7*W-1:0] spec_wcd;
        int len;

        spec_wcd = 70'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000;
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = '0;
        s_last  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_wc_d", wc_d, 0);
        chk("rst_busy", busy, 0);
        #2;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        #1;
        chk("rel_ready_before_edge", s_ready, 0);
        @(negedge clk);
        chk("rel_s_ready", s_ready, 1);
        chk("rel_busy", busy, 0);

        // Single tile with latency profile.
        row = {};
        foreach (spec_row[i]) row.push_back(W'(spec_row[i]));
        send_row(row, 1'b0, 50);
        chk("single_wc_d", wc_d, spec_wcd);
        for (int j = 0; j <= LAT; j++) begin
            @(negedge clk);
            chk($sformatf("single_mvalid_c%0d", j), m_valid, (j == LAT) ? 1 : 0);
        end
        drain("single");

        // Overlap, padding, fresh row after padding.
        seq_row(row, 1, 12);
        send_row(row, 1'b0, 50);
        chk("overlap_wc_d", wc_d, model_last_tile);
        drain("overlap");
        seq_row(row, 1, 9);
        send_row(row, 1'b0, 50);
        chk("pad_wc_d", wc_d, model_last_tile);
        seq_row(row, 21, 7);
        send_row(row, 1'b0, 50);
        chk("newrow_wc_d", wc_d, model_last_tile);
        drain("pad");

        // Randomized rows with random output backpressure.
        mready_mode = 2;
        for (int r = 0; r < 25; r++) begin
            len = int'($urandom_range(1, 23));
            row = {};
            for (int i = 0; i < len; i++) row.push_back(W'($urandom_range(0, 1023)));
            send_row(row, 1'b1, 500);
        end
        mready_mode = 1;
        drain("random");

        // Full output stall: 8 tiles of credit, 9th tile completes at sample 47.
        mready_mode = 0;
        acc_cnt = 0;
        row = {};
        for (int i = 0; i < 60; i++) row.push_back(W'($urandom_range(0, 1023)));
        fork
            send_row(row, 1'b0, 3000);
            begin
                repeat (200) @(negedge clk);
                chk("bp_accepted", acc_cnt, 47);
                chk("bp_s_ready", s_ready, 0);
                chk("bp_m_valid", m_valid, 1);
                mready_mode = 1;
            end
        join
        drain("bp");

        // Reset with results buffered and tiles in flight.
        mready_mode = 0;
        seq_row(row, 100, 7);
        send_row(row, 1'b0, 50);
        seq_row(row, 200, 7);
        send_row(row, 1'b0, 50);
        repeat (LAT + 2) @(negedge clk);
        seq_row(row, 300, 12);
        send_row(row, 1'b0, 50);
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        mready_mode = 1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk("mid_no_mvalid", m_valid, 0);
        end
        chk("mid_busy_after", busy, 0);

        seq_row(row, 7, 8);
        send_row(row, 1'b0, 50);
        drain("recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
